// File: rtl/lx32_arch_pkg.sv
// Architectural parameters and internal control encodings of the LX32 core.
package lx32_arch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ,
    BR_NE,
    BR_LT,
    BR_GE,
    BR_LTU,
    BR_GEU
  } branch_op_e;

  typedef enum logic [1:0] {
    OPA_RS1,
    OPA_PC,
    OPA_ZERO
  } op_a_sel_e;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4
  } wb_sel_e;

endpackage

// File: rtl/lx32_isa_pkg.sv
// RV32I encoding constants and immediate decoding shared by the LX32 core.
// Covers the subset the core executes plus the opcodes it treats as NOPs.
package lx32_isa_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    unique case (fmt)
      IMM_S:   imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{21{instr[31]}}, instr[30:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/lx32_alu.sv
// Combinational integer ALU; shift amounts use only the low five bits of b_i.
module lx32_alu
  import lx32_arch_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_e         op_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = b_i[4:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    result_o = a_i + b_i;
    unique case (op_i)
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $signed(a_i) >>> shamt;
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/lx32_system_core.sv
// Single-cycle RV32I-subset core: decoder, register file, PC logic and branch compare,
// with combinational instruction fetch and a word-wide data port.
module lx32_system_core #(
  parameter logic [31:0] RESET_PC = lx32_arch_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we
);

  import lx32_isa_pkg::*;
  import lx32_arch_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd, rs1, rs2;

  alu_op_e    alu_op, f3_op;
  branch_op_e br_op;
  op_a_sel_e  a_sel;
  wb_sel_e    wb_sel;
  imm_fmt_e   imm_fmt;
  logic       b_imm, rd_we, is_branch, is_jal, is_jalr, is_load, is_store;

  logic [31:0] imm, rs1_val, rs2_val, alu_a, alu_b, alu_result, rd_data, pc4;
  logic        br_taken;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // funct3 names the same operation in OP and OP-IMM; funct7 only selects SUB/SRA.
  always_comb begin
    f3_op = ALU_ADD;
    unique case (funct3)
      F3_SLL:  f3_op = ALU_SLL;
      F3_SLT:  f3_op = ALU_SLT;
      F3_SLTU: f3_op = ALU_SLTU;
      F3_XOR:  f3_op = ALU_XOR;
      F3_SR:   f3_op = ALU_SRL;
      F3_OR:   f3_op = ALU_OR;
      F3_AND:  f3_op = ALU_AND;
      default: f3_op = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_op    = ALU_ADD;
    br_op     = BR_EQ;
    a_sel     = OPA_RS1;
    wb_sel    = WB_ALU;
    imm_fmt   = IMM_I;
    b_imm     = 1'b0;
    rd_we     = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    unique case (opcode)
      OPC_LUI: begin
        a_sel   = OPA_ZERO;
        imm_fmt = IMM_U;
        b_imm   = 1'b1;
        rd_we   = 1'b1;
      end
      OPC_AUIPC: begin
        a_sel   = OPA_PC;
        imm_fmt = IMM_U;
        b_imm   = 1'b1;
        rd_we   = 1'b1;
      end
      OPC_JAL: begin
        imm_fmt = IMM_J;
        is_jal  = 1'b1;
        rd_we   = 1'b1;
        wb_sel  = WB_PC4;
      end
      OPC_JALR: begin
        if (funct3 == F3_JALR) begin
          b_imm   = 1'b1;
          is_jalr = 1'b1;
          rd_we   = 1'b1;
          wb_sel  = WB_PC4;
        end
      end
      OPC_BRANCH: begin
        imm_fmt   = IMM_B;
        is_branch = 1'b1;
        unique case (funct3)
          F3_BEQ:  br_op = BR_EQ;
          F3_BNE:  br_op = BR_NE;
          F3_BLT:  br_op = BR_LT;
          F3_BGE:  br_op = BR_GE;
          F3_BLTU: br_op = BR_LTU;
          F3_BGEU: br_op = BR_GEU;
          default: is_branch = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        if (funct3 == F3_WORD) begin
          b_imm   = 1'b1;
          is_load = 1'b1;
          rd_we   = 1'b1;
          wb_sel  = WB_MEM;
        end
      end
      OPC_STORE: begin
        if (funct3 == F3_WORD) begin
          imm_fmt  = IMM_S;
          b_imm    = 1'b1;
          is_store = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        b_imm  = 1'b1;
        rd_we  = 1'b1;
        alu_op = f3_op;
        if (funct3 == F3_SLL) begin
          rd_we = (funct7 == F7_BASE);
        end else if (funct3 == F3_SR) begin
          rd_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          if (funct7 == F7_ALT) alu_op = ALU_SRA;
        end
      end
      OPC_OP: begin
        alu_op = f3_op;
        if (funct7 == F7_BASE) begin
          rd_we = 1'b1;
        end else if (funct7 == F7_ALT) begin
          if (funct3 == F3_ADD_SUB) begin
            rd_we  = 1'b1;
            alu_op = ALU_SUB;
          end else if (funct3 == F3_SR) begin
            rd_we  = 1'b1;
            alu_op = ALU_SRA;
          end
        end
      end
      default: ;  // FENCE, ECALL, EBREAK and undefined opcodes retire as NOPs.
    endcase
  end

  assign imm     = imm_gen(instr, imm_fmt);
  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf_q[rs2];

  always_comb begin
    alu_a = rs1_val;
    unique case (a_sel)
      OPA_PC:   alu_a = pc_q;
      OPA_ZERO: alu_a = 32'h0;
      default:  alu_a = rs1_val;
    endcase
  end

  assign alu_b = b_imm ? imm : rs2_val;

  lx32_alu u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_result)
  );

  always_comb begin
    br_taken = 1'b0;
    unique case (br_op)
      BR_NE:   br_taken = rs1_val != rs2_val;
      BR_LT:   br_taken = $signed(rs1_val) < $signed(rs2_val);
      BR_GE:   br_taken = $signed(rs1_val) >= $signed(rs2_val);
      BR_LTU:  br_taken = rs1_val < rs2_val;
      BR_GEU:  br_taken = rs1_val >= rs2_val;
      default: br_taken = rs1_val == rs2_val;
    endcase
  end

  // JALR reuses the ALU sum rs1+imm as its target before clearing bit 0.
  assign pc4 = pc_q + 32'd4;
  always_comb begin
    pc_d = pc4;
    if (is_jalr) begin
      pc_d = {alu_result[31:1], 1'b0};
    end else if (is_jal || (is_branch && br_taken)) begin
      pc_d = pc_q + imm;
    end
  end

  always_comb begin
    rd_data = alu_result;
    unique case (wb_sel)
      WB_MEM:  rd_data = mem_rdata;
      WB_PC4:  rd_data = pc4;
      default: rd_data = alu_result;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // NOTE: the register array is reset because software relies on x1..x31 starting at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (rd_we && (rd == 5'(i))) rf_q[i] <= rd_data;
      end
    end
  end

  // The data port is gated by reset so memory never sees a stray store or address.
  assign pc_out    = pc_q;
  assign mem_we    = is_store && rst;
  assign mem_addr  = ((is_load || is_store) && rst) ? alu_result : 32'h0;
  assign mem_wdata = (is_store && rst) ? rs2_val : 32'h0;

endmodule

// File: tb/tb_lx32_system_core.sv
// Directed bench for lx32_system_core with an in-bench memory_sim and console capture.
module tb_lx32_system_core;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] CON   = 32'h0000_07FC;

  logic        clk;
  logic        rst;
  logic [31:0] pc_out, instr, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [512];
  logic        ld_we;
  logic [8:0]  ld_idx;
  logic [31:0] ld_data;
  logic [31:0] con_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] prog [$];

  int n_checks;
  int n_fail;

  lx32_system_core dut (
    .clk       (clk),
    .rst       (rst),
    .pc_out    (pc_out),
    .instr     (instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr     = mem[pc_out[10:2]];
  assign mem_rdata = mem[mem_addr[10:2]];

  always @(posedge clk) begin
    if (ld_we) begin
      mem[ld_idx] <= ld_data;
    end else if (mem_we) begin
      mem[mem_addr[10:2]] <= mem_wdata;
    end
    if (mem_we && rst && mem_addr == CON) begin
      $display("console: %h", mem_wdata);
      con_q.push_back(mem_wdata);
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return enc_i(imm, rs1, 3'b000, rd, OP_IMM);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Writes prog into memory (NOP fill elsewhere) while the core is held in reset.
  task automatic load_prog();
    rst   = 1'b0;
    ld_we = 1'b1;
    for (int i = 0; i < 512; i++) begin
      ld_idx  = 9'(i);
      ld_data = (i < prog.size()) ? prog[i] : NOP;
      @(negedge clk);
    end
    ld_we = 1'b0;
    con_q.delete();
  endtask

  task automatic start_core();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    prog = '{enc_sw(5'd0, 5'd0, 12'h7FC), NOP};
    load_prog();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (pc_out !== 32'h0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: pc=%h we=%b addr=%h wdata=%h, required pc=0 we=0 addr=0 wdata=0",
                 c, pc_out, mem_we, mem_addr, mem_wdata);
      end
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (pc_out !== 32'h0 || mem_we !== 1'b1 || mem_addr !== CON) begin
      n_fail++;
      $display("FAIL reset_first_fetch: pc=%h we=%b addr=%h, required pc=0 we=1 addr=7fc",
               pc_out, mem_we, mem_addr);
    end
    step();
    n_checks++;
    if (pc_out !== 32'h4) begin
      n_fail++;
      $display("FAIL reset_run: pc=%h, required 00000004", pc_out);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (pc_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_async: pc=%h, required 00000000", pc_out);
    end
  endtask

  task automatic test_alu_console();
    prog = '{addi(5'd1, 5'd0, 12'd5), addi(5'd2, 5'd0, 12'hFFD),
             enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), enc_sw(5'd3, 5'd0, 12'h7FC)};
    load_prog();
    start_core();
    repeat (3) step();
    n_checks++;
    if (pc_out !== 32'hC || mem_we !== 1'b1 || mem_addr !== CON || mem_wdata !== 32'h2) begin
      n_fail++;
      $display("FAIL alu_store: pc=%h we=%b addr=%h wdata=%h, required pc=c we=1 addr=7fc wdata=2",
               pc_out, mem_we, mem_addr, mem_wdata);
    end
    repeat (3) step();
    n_checks++;
    if (con_q.size() != 1 || con_q[0] !== 32'h2) begin
      n_fail++;
      $display("FAIL alu_console: %0d entries first=%h, required 1 entry 00000002",
               con_q.size(), (con_q.size() > 0) ? con_q[0] : 32'h0);
    end
  endtask

  task automatic test_load_store();
    prog = '{enc_lui(20'h12345, 5'd1), enc_sw(5'd1, 5'd0, 12'h100),
             enc_i(12'h100, 5'd0, 3'b010, 5'd4, 7'b0000011), enc_sw(5'd4, 5'd0, 12'h7FC)};
    load_prog();
    start_core();
    repeat (2) step();
    n_checks++;
    if (pc_out !== 32'h8 || mem_we !== 1'b0 || mem_addr !== 32'h100 || mem_rdata !== 32'h1234_5000) begin
      n_fail++;
      $display("FAIL lw_port: pc=%h we=%b addr=%h rdata=%h, required pc=8 we=0 addr=100 rdata=12345000",
               pc_out, mem_we, mem_addr, mem_rdata);
    end
    repeat (4) step();
    n_checks++;
    if (con_q.size() != 1 || con_q[0] !== 32'h1234_5000) begin
      n_fail++;
      $display("FAIL ls_console: %0d entries first=%h, required 1 entry 12345000",
               con_q.size(), (con_q.size() > 0) ? con_q[0] : 32'h0);
    end
  endtask

  task automatic test_branches();
    prog = '{addi(5'd1, 5'd0, 12'hFFF), addi(5'd2, 5'd0, 12'd1),
             enc_b(13'd12, 5'd2, 5'd1, 3'b100),
             addi(5'd5, 5'd0, 12'hB), enc_sw(5'd5, 5'd0, 12'h7FC),
             enc_b(13'd12, 5'd2, 5'd1, 3'b110),
             addi(5'd5, 5'd0, 12'hA), enc_sw(5'd5, 5'd0, 12'h7FC)};
    load_prog();
    start_core();
    repeat (3) step();
    n_checks++;
    if (pc_out !== 32'h14) begin
      n_fail++;
      $display("FAIL blt_taken: pc=%h, required 00000014", pc_out);
    end
    step();
    n_checks++;
    if (pc_out !== 32'h18) begin
      n_fail++;
      $display("FAIL bltu_not_taken: pc=%h, required 00000018", pc_out);
    end
    repeat (3) step();
    n_checks++;
    if (con_q.size() != 1 || con_q[0] !== 32'hA) begin
      n_fail++;
      $display("FAIL branch_console: %0d entries first=%h, required 1 entry 0000000a",
               con_q.size(), (con_q.size() > 0) ? con_q[0] : 32'h0);
    end
  endtask

  task automatic test_jumps();
    prog = '{NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP,
             enc_j(21'd8, 5'd1), enc_sw(5'd1, 5'd0, 12'h7FC),
             enc_i(12'h000, 5'd1, 3'b000, 5'd0, 7'b1100111)};
    load_prog();
    start_core();
    repeat (8) step();
    n_checks++;
    if (pc_out !== 32'h20) begin
      n_fail++;
      $display("FAIL jal_reach: pc=%h, required 00000020", pc_out);
    end
    step();
    n_checks++;
    if (pc_out !== 32'h28) begin
      n_fail++;
      $display("FAIL jal_target: pc=%h, required 00000028", pc_out);
    end
    step();
    n_checks++;
    if (pc_out !== 32'h24) begin
      n_fail++;
      $display("FAIL jalr_target: pc=%h, required 00000024", pc_out);
    end
    step();
    n_checks++;
    if (con_q.size() != 1 || con_q[0] !== 32'h24) begin
      n_fail++;
      $display("FAIL jal_link: %0d entries first=%h, required 1 entry 00000024",
               con_q.size(), (con_q.size() > 0) ? con_q[0] : 32'h0);
    end
  endtask

  task automatic test_x0_shifts();
    prog = '{32'hFFFF_FFFF, enc_sw(5'd31, 5'd0, 12'h7FC),
             addi(5'd0, 5'd0, 12'd7), enc_sw(5'd0, 5'd0, 12'h7FC),
             enc_lui(20'h80000, 5'd1),
             enc_i({7'b0100000, 5'd31}, 5'd1, 3'b101, 5'd2, OP_IMM), enc_sw(5'd2, 5'd0, 12'h7FC),
             enc_i({7'b0000000, 5'd31}, 5'd1, 3'b101, 5'd3, OP_IMM), enc_sw(5'd3, 5'd0, 12'h7FC),
             enc_r(7'h00, 5'd0, 5'd1, 3'b010, 5'd4), enc_sw(5'd4, 5'd0, 12'h7FC),
             enc_i(12'hFFF, 5'd1, 3'b100, 5'd5, OP_IMM), enc_sw(5'd5, 5'd0, 12'h7FC),
             enc_r(7'h20, 5'd2, 5'd0, 3'b000, 5'd6), enc_sw(5'd6, 5'd0, 12'h7FC)};
    exp_q = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h1, 32'h7FFF_FFFF, 32'h1};
    load_prog();
    start_core();
    step();
    n_checks++;
    if (pc_out !== 32'h4) begin
      n_fail++;
      $display("FAIL illegal_nop: pc=%h, required 00000004", pc_out);
    end
    repeat (15) step();
    n_checks++;
    if (con_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL x0_shift_count: %0d console writes, required %0d", con_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < con_q.size(); i++) begin
      n_checks++;
      if (con_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL x0_shift_value[%0d]: got %h, required %h", i, con_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    ld_we    = 1'b0;
    ld_idx   = 9'd0;
    ld_data  = NOP;
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_alu_console();
    test_load_store();
    test_branches();
    test_jumps();
    test_x0_shifts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
